id_ex_hazard_stage: RTL and testbench
=====================================

// Module: id_ex_hazard_stage
// PURPOSE
//  ID/EX pipeline register with an integrated load-use interlock. It sits directly upstream of the
//  EX-stage forwarding unit and supplies the id_ex Rs1/Rs2/Rd/RegWrite fields that unit compares.
//  On a load-use hazard it holds PC and IF/ID and injects one bubble into EX.
//  On a taken-branch flush it squashes the instruction entering EX.
//  It also keeps a saturating stall counter for performance debug.
// PARAMETERS
//  XLEN     32  datapath width (PC, register data, immediate)
//  CTRL_W   8   width of the opaque EX/MEM/WB control bundle carried through
//  CNT_W    16  width of the stall counter
// PORTS
//  clk             in   1       clock; all state updates on the rising edge
//  rst             in   1       synchronous, active-high reset
//  if_id_valid     in   1       IF/ID holds a real instruction
//  if_id_pc        in   XLEN    PC of the decoding instruction
//  if_id_rs1       in   5       source register 1 index
//  if_id_rs2       in   5       source register 2 index
//  if_id_rd        in   5       destination register index
//  if_id_rdata1    in   XLEN    register-file read data for rs1
//  if_id_rdata2    in   XLEN    register-file read data for rs2
//  if_id_imm       in   XLEN    sign-extended immediate
//  if_id_ctrl      in   CTRL_W  decoded control bundle (ALU op, src selects, ...)
//  if_id_regwrite  in   1       instruction writes rd
//  if_id_memread   in   1       instruction is a load
//  flush           in   1       branch/jump taken in EX; squash ID instruction this cycle
//  id_ex_valid     out  1       EX holds a real instruction
//  id_ex_pc, id_ex_rdata1, id_ex_rdata2, id_ex_imm   out  XLEN   registered copies
//  id_ex_rs1, id_ex_rs2, id_ex_rd                    out  5      registered copies
//  id_ex_ctrl      out  CTRL_W  registered control bundle
//  id_ex_regwrite  out  1       registered RegWrite (to forwarding unit via EX/MEM)
//  id_ex_memread   out  1       registered MemRead
//  stall           out  1       combinational; hold PC and IF/ID this cycle
//  stall_count     out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  hazard = if_id_valid & id_ex_valid & id_ex_memread & (id_ex_rd!=0)
//           & (id_ex_rd==if_id_rs1 | id_ex_rd==if_id_rs2)
//   - Both sources are always compared (conservative).
//  stall = hazard & ~flush. It is purely combinational from registered state and inputs.
//  Bubble: valid, regwrite, memread, ctrl, rs1, rs2 and rd all 0. Data fields (pc/rdata/imm) are 0.
//  Per rising edge, in priority order:
//   1. rst: all id_ex_* outputs 0, stall_count 0.
//   2. flush: load a bubble. Flush wins over a simultaneous hazard; stall stays low.
//   3. hazard: load a bubble. The IF/ID instruction is re-presented next cycle.
//   4. else: capture all if_id_* fields. If if_id_valid=0, capture a bubble instead.
//  Latency: one cycle from if_id_* to id_ex_*.
//  A load-use stall always lasts exactly 1 cycle: the bubble clears id_ex_memread.
//  Back-to-back loads with a dependency therefore stall once per pair.
//  stall_count increments by 1 each cycle stall=1 and saturates at all-ones (no wrap).
//  The counter is not affected by flush.
//  rst mid-stall: the next cycle shows a bubble in EX, stall=0, counter 0.
//  A bubble has rd=0 and regwrite=0, so the downstream forwarding unit never matches it.
// TESTING
//  1. rst held 2 cycles with random inputs -> all id_ex_* = 0, stall=0, stall_count=0.
//  2. lw x5 then add x6,x5,x7 -> stall=1 for 1 cycle, bubble in EX, add enters EX the next
//     cycle, stall_count=1.
//  3. lw x0 then add x6,x0,x1 -> no stall (rd=0 exempt).
//  4. lw x5 followed by dependent add with flush=1 in the same cycle -> stall=0,
//     id_ex_valid=0 next cycle, stall_count unchanged.
//  5. Independent stream (no loads), if_id_valid=1 -> each instruction appears on id_ex_*
//     exactly 1 cycle later, fields bit-exact.
//  6. Force stall_count to 0xFFFE and cause 3 stalls -> reads 0xFFFF and holds.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with a load-use interlock and a saturating stall counter.
//
// A load-use hazard holds PC and IF/ID for one cycle and puts a bubble into EX.
// A taken-branch flush squashes the instruction entering EX, and it takes priority
// over a hazard in the same cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_id_*                  decoded instruction fields from the IF/ID register
//   flush                    taken branch/jump in EX; squash the ID instruction
//   id_ex_*                  registered copies presented to EX and the forwarding unit
//   stall                    combinational; hold PC and IF/ID this cycle
//   stall_count              saturating count of stall cycles
module id_ex_hazard_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_id_valid,
  input  logic [XLEN-1:0]   if_id_pc,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic [4:0]        if_id_rd,
  input  logic [XLEN-1:0]   if_id_rdata1,
  input  logic [XLEN-1:0]   if_id_rdata2,
  input  logic [XLEN-1:0]   if_id_imm,
  input  logic [CTRL_W-1:0] if_id_ctrl,
  input  logic              if_id_regwrite,
  input  logic              if_id_memread,
  input  logic              flush,
  output logic              id_ex_valid,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [XLEN-1:0]   id_ex_rdata1,
  output logic [XLEN-1:0]   id_ex_rdata2,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [4:0]        id_ex_rs1,
  output logic [4:0]        id_ex_rs2,
  output logic [4:0]        id_ex_rd,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_regwrite,
  output logic              id_ex_memread,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  logic hazard;
  logic bubble;

  // Both sources are compared even if the instruction does not read rs2: conservative
  // but needs no decode information.
  always_comb begin
    hazard = if_id_valid & id_ex_valid & id_ex_memread & (id_ex_rd != 5'd0) &
             ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
    stall  = hazard & ~flush;
    bubble = flush | hazard | ~if_id_valid;
  end

  // The bubble clears id_ex_memread, so a load-use stall can never last more than one cycle.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rdata1   <= '0;
      id_ex_rdata2   <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= 5'd0;
      id_ex_rs2      <= 5'd0;
      id_ex_rd       <= 5'd0;
      id_ex_ctrl     <= '0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
    end else begin
      id_ex_valid    <= 1'b1;
      id_ex_pc       <= if_id_pc;
      id_ex_rdata1   <= if_id_rdata1;
      id_ex_rdata2   <= if_id_rdata2;
      id_ex_imm      <= if_id_imm;
      id_ex_rs1      <= if_id_rs1;
      id_ex_rs2      <= if_id_rs2;
      id_ex_rd       <= if_id_rd;
      id_ex_ctrl     <= if_id_ctrl;
      id_ex_regwrite <= if_id_regwrite;
      id_ex_memread  <= if_id_memread;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
module tb_id_ex_hazard_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_rdata1, if_id_rdata2, if_id_imm;
  logic [4:0]  if_id_rs1, if_id_rs2, if_id_rd;
  logic [7:0]  if_id_ctrl;
  logic        if_id_regwrite, if_id_memread, flush;

  logic        id_ex_valid, id_ex_regwrite, id_ex_memread, stall;
  logic [31:0] id_ex_pc, id_ex_rdata1, id_ex_rdata2, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [7:0]  id_ex_ctrl;
  logic [15:0] stall_count;

  // Narrow-counter instance shares all inputs; used to reach saturation quickly.
  logic        s_valid, s_regwrite, s_memread, s_stall;
  logic [31:0] s_pc, s_rdata1, s_rdata2, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [7:0]  s_ctrl;
  logic [1:0]  s_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
    .if_id_rdata1(if_id_rdata1), .if_id_rdata2(if_id_rdata2), .if_id_imm(if_id_imm),
    .if_id_ctrl(if_id_ctrl), .if_id_regwrite(if_id_regwrite), .if_id_memread(if_id_memread),
    .flush(flush), .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
    .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2), .id_ex_imm(id_ex_imm),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_ctrl(id_ex_ctrl), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .stall(stall), .stall_count(stall_count)
  );

  id_ex_hazard_stage #(.XLEN(32), .CTRL_W(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
    .if_id_rdata1(if_id_rdata1), .if_id_rdata2(if_id_rdata2), .if_id_imm(if_id_imm),
    .if_id_ctrl(if_id_ctrl), .if_id_regwrite(if_id_regwrite), .if_id_memread(if_id_memread),
    .flush(flush), .id_ex_valid(s_valid), .id_ex_pc(s_pc),
    .id_ex_rdata1(s_rdata1), .id_ex_rdata2(s_rdata2), .id_ex_imm(s_imm),
    .id_ex_rs1(s_rs1), .id_ex_rs2(s_rs2), .id_ex_rd(s_rd),
    .id_ex_ctrl(s_ctrl), .id_ex_regwrite(s_regwrite), .id_ex_memread(s_memread),
    .stall(s_stall), .stall_count(s_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic [7:0] ctrl,
                       input logic rw, input logic mr);
    if_id_valid = v;  if_id_pc = pc;  if_id_rs1 = rs1;  if_id_rs2 = rs2;  if_id_rd = rd;
    if_id_rdata1 = d1;  if_id_rdata2 = d2;  if_id_imm = imm;  if_id_ctrl = ctrl;
    if_id_regwrite = rw;  if_id_memread = mr;
    #1;
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, ".valid"}, id_ex_valid, 1'b0);
    chk({tag, ".rd"}, id_ex_rd, 5'd0);
    chk({tag, ".regwrite"}, id_ex_regwrite, 1'b0);
    chk({tag, ".memread"}, id_ex_memread, 1'b0);
    chk({tag, ".pc"}, id_ex_pc, 32'd0);
    chk({tag, ".ctrl"}, id_ex_ctrl, 8'd0);
  endtask

  // lw x5 followed by add x6,x5,x7: one stall, then the add reaches EX.
  task automatic load_use(input logic [15:0] exp_big, input logic [1:0] exp_small);
    drive(1, 32'h400, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h8, 8'h21, 1, 1);
    tick();
    drive(1, 32'h404, 5'd5, 5'd7, 5'd6, 32'hA, 32'hB, 32'h0, 8'h03, 1, 0);
    chk("lu.stall", stall, 1'b1);
    tick();
    check_bubble("lu.bubble");
    chk("lu.stall_after", stall, 1'b0);
    chk("lu.count", stall_count, exp_big);
    chk("lu.count_small", s_count, exp_small);
    tick();
    chk("lu.add_rd", id_ex_rd, 5'd6);
  endtask

  initial begin
    flush = 1'b0;
    // 1. Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive($urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
            $urandom, $urandom, 8'($urandom), $urandom, $urandom);
      tick();
    end
    check_bubble("rst");
    chk("rst.rs1", id_ex_rs1, 5'd0);
    chk("rst.rdata1", id_ex_rdata1, 32'd0);
    chk("rst.stall", stall, 1'b0);
    chk("rst.count", stall_count, 16'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // 2. Load-use: lw x5 ; add x6,x5,x7
    drive(1, 32'h100, 5'd1, 5'd0, 5'd5, 32'h11, 32'h0, 32'h4, 8'h21, 1, 1);
    tick();
    chk("lw.rd", id_ex_rd, 5'd5);
    chk("lw.memread", id_ex_memread, 1'b1);
    chk("lw.pc", id_ex_pc, 32'h100);
    drive(1, 32'h104, 5'd5, 5'd7, 5'd6, 32'h55, 32'h77, 32'h0, 8'h03, 1, 0);
    chk("t2.stall", stall, 1'b1);
    tick();
    check_bubble("t2.bubble");
    chk("t2.stall_clear", stall, 1'b0);
    chk("t2.count", stall_count, 16'd1);
    tick();
    chk("t2.add_valid", id_ex_valid, 1'b1);
    chk("t2.add_pc", id_ex_pc, 32'h104);
    chk("t2.add_rd", id_ex_rd, 5'd6);
    chk("t2.add_rs1", id_ex_rs1, 5'd5);
    chk("t2.add_rdata2", id_ex_rdata2, 32'h77);

    // 3. lw x0 ; add x6,x0,x1 -> no stall
    drive(1, 32'h200, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 8'h21, 1, 1);
    tick();
    drive(1, 32'h204, 5'd0, 5'd1, 5'd6, 32'h0, 32'h9, 32'h0, 8'h03, 1, 0);
    chk("t3.stall", stall, 1'b0);
    tick();
    chk("t3.valid", id_ex_valid, 1'b1);
    chk("t3.pc", id_ex_pc, 32'h204);
    chk("t3.count", stall_count, 16'd1);

    // 4. Hazard with simultaneous flush
    drive(1, 32'h300, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 8'h21, 1, 1);
    tick();
    drive(1, 32'h304, 5'd5, 5'd7, 5'd6, 32'h1, 32'h2, 32'h0, 8'h03, 1, 0);
    flush = 1'b1;
    #1;
    chk("t4.stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    check_bubble("t4.squash");
    chk("t4.count", stall_count, 16'd1);

    // 5. Independent stream, one-cycle latency, bit-exact
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [7:0]  ctrl;
      pc = 32'h1000 + 32'(i) * 4;  d1 = 32'hDEAD0000 + 32'(i);  d2 = ~d1;
      imm = 32'hFFFFF000 | 32'(i);  rs1 = 5'(i + 10);  rs2 = 5'(31 - i);  rd = 5'(i + 1);
      ctrl = 8'hA0 + 8'(i);
      drive(1, pc, rs1, rs2, rd, d1, d2, imm, ctrl, i[0], 0);
      chk("t5.stall", stall, 1'b0);
      tick();
      chk("t5.pc", id_ex_pc, pc);
      chk("t5.rdata1", id_ex_rdata1, d1);
      chk("t5.rdata2", id_ex_rdata2, d2);
      chk("t5.imm", id_ex_imm, imm);
      chk("t5.rs1", id_ex_rs1, rs1);
      chk("t5.rs2", id_ex_rs2, rs2);
      chk("t5.rd", id_ex_rd, rd);
      chk("t5.ctrl", id_ex_ctrl, ctrl);
      chk("t5.regwrite", id_ex_regwrite, i[0]);
      chk("t5.valid", id_ex_valid, 1'b1);
    end
    // if_id_valid=0 must produce a bubble even with live-looking fields
    drive(0, 32'h2000, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7, 8'hFF, 1, 1);
    tick();
    check_bubble("t5.invalid");

    // Reset in the middle of a stall
    drive(1, 32'h500, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 8'h21, 1, 1);
    tick();
    drive(1, 32'h504, 5'd0, 5'd9, 5'd4, 32'h0, 32'h0, 32'h0, 8'h03, 1, 0);
    chk("rstmid.stall_before", stall, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bubble("rstmid");
    chk("rstmid.stall", stall, 1'b0);
    chk("rstmid.count", stall_count, 16'd0);

    // 6. Saturation on the 2-bit instance; the 16-bit counter keeps counting
    load_use(16'd1, 2'd1);
    load_use(16'd2, 2'd2);
    load_use(16'd3, 2'd3);
    load_use(16'd4, 2'd3);
    load_use(16'd5, 2'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
